// File: rtl/leaderboard_ranked_if.sv
// Request, result and read-port signals between a stopwatch front end and the leaderboard.
// The master side drives requests and read addresses; the slave side is the leaderboard.
interface leaderboard_ranked_if #(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 3
);
    logic [TIME_W-1:0] time_in;
    logic              time_valid;
    logic [1:0]        stopwatch_mode;
    logic              clear;
    logic              busy;
    logic              insert_done;
    logic [DEPTH-1:0]  rank_hit;
    logic              rd_board;
    logic [IDX_W-1:0]  rd_rank;
    logic [TIME_W-1:0] rd_time;
    logic              rd_occupied;

    modport master (
        output time_in, time_valid, stopwatch_mode, clear, rd_board, rd_rank,
        input  busy, insert_done, rank_hit, rd_time, rd_occupied
    );

    modport slave (
        input  time_in, time_valid, stopwatch_mode, clear, rd_board, rd_rank,
        output busy, insert_done, rank_hit, rd_time, rd_occupied
    );
endinterface

// File: rtl/leaderboard_ranked.sv
// Two sorted top-DEPTH stopwatch boards (FAST ascending, SLOW descending) filled through an
// IDLE/COMPARE/WRITE insertion FSM, with a registered random-access read port.
module leaderboard_ranked #(
    parameter int TIME_W = 22,
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    leaderboard_ranked_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITE} state_t;

    state_t            state;
    logic              busy_q;
    logic              insert_done_q;
    logic [DEPTH-1:0]  rank_hit_q;
    logic [TIME_W-1:0] rd_time_q;
    logic              rd_occupied_q;

    // Board 0 is FAST, board 1 is SLOW, matching the rd_board encoding.
    logic [TIME_W-1:0] entry [2][DEPTH];
    logic [DEPTH-1:0]  occ   [2];

    logic [TIME_W-1:0] time_p0;
    logic              board_p0;
    logic [IDX_W-1:0]  pos_p1;

    logic              accept;
    logic [IDX_W-1:0]  beat_cnt;
    logic [TIME_W-1:0] rd_time_nxt;
    logic              rd_occupied_nxt;

    assign accept = (state == IDLE) && bus.time_valid && !bus.clear &&
                    ((bus.stopwatch_mode == 2'b01) || (bus.stopwatch_mode == 2'b10));

    // Boards are kept sorted, so the count of entries that beat the new value is its slot.
    always_comb begin
        beat_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[board_p0][i] &&
                (board_p0 ? (entry[board_p0][i] >= time_p0)
                          : (entry[board_p0][i] <= time_p0))) begin
                beat_cnt = beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rd_time_nxt     = '0;
        rd_occupied_nxt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_rank == IDX_W'(i)) begin
                rd_time_nxt     = entry[bus.rd_board][i];
                rd_occupied_nxt = occ[bus.rd_board][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy_q        <= 1'b0;
            insert_done_q <= 1'b0;
            rank_hit_q    <= '0;
            rd_time_q     <= '0;
            rd_occupied_q <= 1'b0;
            board_p0      <= 1'b0;
            pos_p1        <= '0;
            for (int b = 0; b < 2; b++) begin
                occ[b] <= '0;
                for (int i = 0; i < DEPTH; i++) entry[b][i] <= '0;
            end
        end else begin
            rd_time_q     <= rd_time_nxt;
            rd_occupied_q <= rd_occupied_nxt;
            insert_done_q <= 1'b0;
            rank_hit_q    <= '0;
            if (bus.clear) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                for (int b = 0; b < 2; b++) begin
                    occ[b] <= '0;
                    for (int i = 0; i < DEPTH; i++) entry[b][i] <= '0;
                end
            end else begin
                case (state)
                    // p0: capture the request
                    IDLE: begin
                        if (accept) begin
                            time_p0  <= bus.time_in;
                            board_p0 <= (bus.stopwatch_mode == 2'b01);
                            state    <= COMPARE;
                            busy_q   <= 1'b1;
                        end
                    end
                    // p1: register the insertion slot
                    COMPARE: begin
                        pos_p1 <= beat_cnt;
                        state  <= WRITE;
                    end
                    // p2: shift the tail down and drop the new value in
                    WRITE: begin
                        if (pos_p1 < IDX_W'(DEPTH)) begin
                            for (int i = 1; i < DEPTH; i++) begin
                                if (IDX_W'(i) > pos_p1) begin
                                    entry[board_p0][i] <= entry[board_p0][i-1];
                                    occ[board_p0][i]   <= occ[board_p0][i-1];
                                end
                            end
                            for (int i = 0; i < DEPTH; i++) begin
                                if (IDX_W'(i) == pos_p1) begin
                                    entry[board_p0][i] <= time_p0;
                                    occ[board_p0][i]   <= 1'b1;
                                end
                            end
                            rank_hit_q <= DEPTH'(1) << pos_p1;
                        end
                        insert_done_q <= 1'b1;
                        state         <= IDLE;
                        busy_q        <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.insert_done = insert_done_q;
    assign bus.rank_hit    = rank_hit_q;
    assign bus.rd_time     = rd_time_q;
    assign bus.rd_occupied = rd_occupied_q;
endmodule

// File: tb/tb_leaderboard_ranked.sv
// Bench for leaderboard_ranked: three instances (DEPTH 3, 1, 8) share one stimulus stream and
// are each compared with a sorted-list reference model of both boards.
module tb_leaderboard_ranked;
    localparam int TW = 22;
    localparam int NK = 3;
    localparam int DEPTHS [NK] = '{3, 1, 8};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] time_in = '0;
    logic          time_valid = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          clear = 1'b0;
    logic          rd_board = 1'b0;
    logic [3:0]    rd_rank = '0;

    always #5 clk = ~clk;

    leaderboard_ranked_if #(.TIME_W(TW), .DEPTH(3), .IDX_W(3)) if_a ();
    leaderboard_ranked_if #(.TIME_W(TW), .DEPTH(1), .IDX_W(3)) if_b ();
    leaderboard_ranked_if #(.TIME_W(TW), .DEPTH(8), .IDX_W(4)) if_c ();

    assign if_a.time_in = time_in;  assign if_b.time_in = time_in;  assign if_c.time_in = time_in;
    assign if_a.time_valid = time_valid;
    assign if_b.time_valid = time_valid;
    assign if_c.time_valid = time_valid;
    assign if_a.stopwatch_mode = mode;
    assign if_b.stopwatch_mode = mode;
    assign if_c.stopwatch_mode = mode;
    assign if_a.clear = clear;  assign if_b.clear = clear;  assign if_c.clear = clear;
    assign if_a.rd_board = rd_board;
    assign if_b.rd_board = rd_board;
    assign if_c.rd_board = rd_board;
    assign if_a.rd_rank = rd_rank[2:0];
    assign if_b.rd_rank = rd_rank[2:0];
    assign if_c.rd_rank = rd_rank;

    leaderboard_ranked #(.TIME_W(TW), .DEPTH(3), .IDX_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    leaderboard_ranked #(.TIME_W(TW), .DEPTH(1), .IDX_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    leaderboard_ranked #(.TIME_W(TW), .DEPTH(8), .IDX_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    logic          busy_o [NK];
    logic          done_o [NK];
    logic          occ_o  [NK];
    logic [7:0]    rh_o   [NK];
    logic [TW-1:0] rdt_o  [NK];

    assign busy_o[0] = if_a.busy;         assign busy_o[1] = if_b.busy;         assign busy_o[2] = if_c.busy;
    assign done_o[0] = if_a.insert_done;  assign done_o[1] = if_b.insert_done;  assign done_o[2] = if_c.insert_done;
    assign occ_o[0]  = if_a.rd_occupied;  assign occ_o[1]  = if_b.rd_occupied;  assign occ_o[2]  = if_c.rd_occupied;
    assign rdt_o[0]  = if_a.rd_time;      assign rdt_o[1]  = if_b.rd_time;      assign rdt_o[2]  = if_c.rd_time;
    assign rh_o[0]   = 8'(if_a.rank_hit);
    assign rh_o[1]   = 8'(if_b.rank_hit);
    assign rh_o[2]   = if_c.rank_hit;

    // Reference: each board is a sorted list of at most DEPTH values, best first.
    logic [TW-1:0] mv [NK][2][8];
    int            mn [NK][2];
    logic [7:0]    exp_rh [NK];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NK; k++) begin
            mn[k][0] = 0;
            mn[k][1] = 0;
        end
    endtask

    task automatic model_insert(input logic [1:0] m, input logic [TW-1:0] t);
        int b;
        int pos;
        int last;
        b = (m == 2'b01) ? 1 : 0;
        for (int k = 0; k < NK; k++) begin
            pos = 0;
            for (int j = 0; j < mn[k][b]; j++) begin
                if ((b == 0) ? (mv[k][b][j] <= t) : (mv[k][b][j] >= t)) pos++;
            end
            if (pos < DEPTHS[k]) begin
                last = (mn[k][b] < DEPTHS[k]) ? mn[k][b] : DEPTHS[k] - 1;
                for (int j = last; j > pos; j--) mv[k][b][j] = mv[k][b][j-1];
                mv[k][b][pos] = t;
                if (mn[k][b] < DEPTHS[k]) mn[k][b]++;
                exp_rh[k] = 8'(1 << pos);
            end else begin
                exp_rh[k] = 8'h00;
            end
        end
    endtask

    task automatic do_insert(input logic [1:0] m, input logic [TW-1:0] t, input string tag);
        logic ok;
        ok = (m == 2'b01) || (m == 2'b10);
        time_in    = t;
        mode       = m;
        time_valid = 1'b1;
        step();
        time_valid = 1'b0;
        for (int k = 0; k < NK; k++) check($sformatf("%s_busy_k%0d", tag, k), 64'(busy_o[k]), 64'(ok));
        step();
        for (int k = 0; k < NK; k++) check($sformatf("%s_early_done_k%0d", tag, k), 64'(done_o[k]), 64'd0);
        step();
        if (ok) model_insert(m, t);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("%s_done_k%0d", tag, k), 64'(done_o[k]), 64'(ok));
            check($sformatf("%s_rank_hit_k%0d", tag, k), 64'(rh_o[k]), ok ? 64'(exp_rh[k]) : 64'd0);
            check($sformatf("%s_idle_k%0d", tag, k), 64'(busy_o[k]), 64'd0);
        end
    endtask

    task automatic check_boards(input string tag);
        logic [TW-1:0] et;
        logic          eo;
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r <= 8; r++) begin
                rd_board = b[0];
                rd_rank  = 4'(r);
                step();
                for (int k = 0; k < NK; k++) begin
                    if (k == 2 || r < 8) begin
                        eo = (r < DEPTHS[k]) && (r < mn[k][b]);
                        et = eo ? mv[k][b][r] : '0;
                        check($sformatf("%s_rd_time_k%0d_b%0d_r%0d", tag, k, b, r), 64'(rdt_o[k]), 64'(et));
                        check($sformatf("%s_rd_occ_k%0d_b%0d_r%0d", tag, k, b, r), 64'(occ_o[k]), 64'(eo));
                    end
                end
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [6] = '{0, 1, 1, 0, 1, 1};
        logic [1:0]    rm;
        logic [TW-1:0] rt;
        int            sel;

        model_clear();
        rst_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < NK; k++) begin
            check($sformatf("rst_busy_k%0d", k), 64'(busy_o[k]), 64'd0);
            check($sformatf("rst_done_k%0d", k), 64'(done_o[k]), 64'd0);
            check($sformatf("rst_rank_hit_k%0d", k), 64'(rh_o[k]), 64'd0);
            check($sformatf("rst_rd_time_k%0d", k), 64'(rdt_o[k]), 64'd0);
            check($sformatf("rst_rd_occ_k%0d", k), 64'(occ_o[k]), 64'd0);
        end
        rst_n = 1'b1;
        step();
        check_boards("after_reset");

        // Basic FAST ordering on the DEPTH=3 board.
        do_insert(2'b10, 22'd500, "f500");
        check("plan_rh_500", 64'(rh_o[0]), 64'd1);
        do_insert(2'b10, 22'd300, "f300");
        check("plan_rh_300", 64'(rh_o[0]), 64'd1);
        do_insert(2'b10, 22'd400, "f400");
        check("plan_rh_400", 64'(rh_o[0]), 64'd2);
        check_boards("fast3");

        do_insert(2'b10, 22'd600, "f600");
        check("plan_rh_600_miss", 64'(rh_o[0]), 64'd0);
        do_insert(2'b10, 22'd100, "f100");
        check("plan_rh_100", 64'(rh_o[0]), 64'd1);
        check_boards("fast_evict");

        do_insert(2'b01, 22'd700, "s700a");
        do_insert(2'b01, 22'd700, "s700b");
        check("plan_rh_tie", 64'(rh_o[0]), 64'd2);
        check_boards("slow_tie");

        // time_valid held for six edges: two acceptances, three cycles apart.
        do_clear();
        time_in    = 22'd50;
        mode       = 2'b10;
        time_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("hold_busy_c%0d", c), 64'(busy_o[0]), 64'(pat[c]));
            step();
            if (c == 2 || c == 5) model_insert(2'b10, 22'd50);
            for (int k = 0; k < NK; k++) begin
                check($sformatf("hold_done_c%0d_k%0d", c, k), 64'(done_o[k]), 64'(c == 2 || c == 5));
                if (c == 2 || c == 5)
                    check($sformatf("hold_rh_c%0d_k%0d", c, k), 64'(rh_o[k]), 64'(exp_rh[k]));
            end
        end
        time_valid = 1'b0;
        check_boards("hold");

        // Clear during COMPARE aborts the request.
        time_in    = 22'd77;
        mode       = 2'b10;
        time_valid = 1'b1;
        step();
        time_valid = 1'b0;
        do_clear();
        for (int k = 0; k < NK; k++) check($sformatf("abort_busy_k%0d", k), 64'(busy_o[k]), 64'd0);
        repeat (2) begin
            step();
            for (int k = 0; k < NK; k++) check($sformatf("abort_done_k%0d", k), 64'(done_o[k]), 64'd0);
        end
        check_boards("abort");

        // Clear with a simultaneous request drops the request.
        time_valid = 1'b1;
        do_clear();
        time_valid = 1'b0;
        for (int k = 0; k < NK; k++) check($sformatf("clrreq_busy_k%0d", k), 64'(busy_o[k]), 64'd0);

        do_insert(2'b00, 22'd123, "mode00");
        do_insert(2'b11, 22'd456, "mode11");
        check_boards("no_board");

        // Descending then ascending sequences on both boards.
        for (int i = 0; i < 10; i++) begin
            do_insert(2'b10, 22'(1000 - 100 * i), $sformatf("desc_f%0d", i));
            do_insert(2'b01, 22'(1000 - 100 * i), $sformatf("desc_s%0d", i));
        end
        check_boards("desc");
        do_clear();
        for (int i = 0; i < 10; i++) begin
            do_insert(2'b10, 22'(100 * (i + 1)), $sformatf("asc_f%0d", i));
            do_insert(2'b01, 22'(100 * (i + 1)), $sformatf("asc_s%0d", i));
        end
        check_boards("asc");

        // Random traffic with ties, zero and full-scale values.
        do_clear();
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7);
            rm  = (sel < 3) ? 2'b10 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b00 : 2'b11;
            sel = $urandom_range(0, 3);
            rt  = (sel == 0) ? 22'($urandom_range(0, 15)) :
                  (sel == 1) ? 22'd0 :
                  (sel == 2) ? 22'h3FFFFF : 22'($urandom);
            do_insert(rm, rt, $sformatf("rnd%0d", n));
            if (n % 15 == 14) check_boards($sformatf("rnd_b%0d", n));
            if (n == 29) do_clear();
        end
        check_boards("rnd_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
